// File: rtl/et_err_sim_pkg.sv
// Shared types for the error-simulation trigger sequencer: FSM states,
// run-mode encodings and burst-ID values.
package et_err_sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TLK_BURST,
        WAIT_TRIG,
        HDR_SHIFT,
        DC_BURST,
        DONE
    } err_sim_state_t;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_TLK   = 2'd1;
    localparam logic [1:0] MODE_ONCE  = 2'd2;
    localparam logic [1:0] MODE_REARM = 2'd3;

    localparam logic BID_TLK = 1'b0;
    localparam logic BID_DC  = 1'b1;

endpackage

// File: rtl/et_err_sim_hdr_deser.sv
// Serial header capture: stores one trigger-line bit per shift cycle and,
// on the last bit, flags completion and whether the header matched.
module et_err_sim_hdr_deser #(
    parameter int              HDR_W     = 3,
    parameter logic [HDR_W-1:0] HDR_MATCH = 3'b010
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic shift_en,
    input  logic bit_in,
    output logic hdr_done,
    output logic hdr_match
);

    localparam int IW = (HDR_W > 1) ? $clog2(HDR_W) : 1;

    logic [IW-1:0]    idx_q;
    logic [HDR_W-1:0] hdr_q;
    logic [HDR_W-1:0] cmp;

    // The bit on the line this cycle is compared directly, so the decision
    // lands on the same edge that samples the final header bit.
    always_comb begin
        for (int i = 0; i < HDR_W; i++)
            cmp[i] = (IW'(i) == idx_q) ? bit_in : hdr_q[i];
    end

    assign hdr_done  = shift_en && (idx_q == IW'(HDR_W - 1));
    assign hdr_match = hdr_done && (cmp == HDR_MATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            hdr_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
            hdr_q <= '0;
        end else if (shift_en) begin
            hdr_q[idx_q] <= bit_in;
            idx_q        <= hdr_done ? '0 : idx_q + IW'(1);
        end
    end

endmodule

// File: rtl/et_err_sim_seq.sv
// Error-simulation trigger sequencer: plays a TLK address burst, then
// header-gated DC bursts into the ADC playback memory.
module et_err_sim_seq
    import et_err_sim_pkg::*;
#(
    parameter int               ADDR_W    = 12,
    parameter int               BURST_LEN = 2048,
    parameter int               DC_BASE   = 2048,
    parameter int               HDR_W     = 3,
    parameter logic [HDR_W-1:0] HDR_MATCH = 3'b010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_live,
    input  logic              user_ena,
    input  logic [1:0]        mode,
    input  logic              trig_to_adc,
    output logic              out_rena,
    output logic [ADDR_W-1:0] out_raddr,
    output logic              out_burst_id,
    output logic              busy,
    output logic              done,
    output logic [7:0]        hdr_mismatch_cnt
);

    if (BURST_LEN < 1 || BURST_LEN > (1 << ADDR_W) ||
        DC_BASE + BURST_LEN > (1 << ADDR_W) || HDR_W < 1 || HDR_W > 8) begin : g_cfg_err
        $error("et_err_sim_seq: invalid parameter set");
    end

    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] DC_ADDR0 = ADDR_W'(DC_BASE);

    err_sim_state_t    state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rena_d, bid_d, hdr_shift, hdr_done, hdr_match;
    logic [ADDR_W-1:0] raddr_d;
    logic [7:0]        mis_d;

    et_err_sim_hdr_deser #(.HDR_W(HDR_W), .HDR_MATCH(HDR_MATCH)) u_hdr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!in_live),
        .shift_en  (hdr_shift),
        .bit_in    (trig_to_adc),
        .hdr_done  (hdr_done),
        .hdr_match (hdr_match)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        rena_d    = 1'b0;
        raddr_d   = out_raddr;
        bid_d     = out_burst_id;
        mis_d     = hdr_mismatch_cnt;
        hdr_shift = 1'b0;
        if (!in_live) begin
            state_d = IDLE;
            mode_d  = MODE_OFF;
            cnt_d   = '0;
            raddr_d = '0;
            bid_d   = BID_TLK;
            mis_d   = '0;
        end else if (user_ena) begin
            // With user_ena low everything above is simply held: a pause.
            case (state_q)
                IDLE: if (mode != MODE_OFF) begin
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = TLK_BURST;
                end
                TLK_BURST: begin
                    rena_d  = 1'b1;
                    raddr_d = cnt_q[ADDR_W-1:0];
                    bid_d   = BID_TLK;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = (mode_q == MODE_TLK) ? DONE : WAIT_TRIG;
                    end else begin
                        cnt_d = cnt_q + (ADDR_W + 1)'(1);
                    end
                end
                WAIT_TRIG: if (trig_to_adc) state_d = HDR_SHIFT;
                HDR_SHIFT: begin
                    hdr_shift = 1'b1;
                    if (hdr_done) begin
                        if (hdr_match) begin
                            state_d = DC_BURST;
                        end else begin
                            state_d = WAIT_TRIG;
                            if (hdr_mismatch_cnt != 8'hFF) mis_d = hdr_mismatch_cnt + 8'd1;
                        end
                    end
                end
                DC_BURST: begin
                    rena_d  = 1'b1;
                    raddr_d = DC_ADDR0 + cnt_q[ADDR_W-1:0];
                    bid_d   = BID_DC;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = (mode_q == MODE_ONCE) ? DONE : WAIT_TRIG;
                    end else begin
                        cnt_d = cnt_q + (ADDR_W + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            mode_q           <= MODE_OFF;
            cnt_q            <= '0;
            out_rena         <= 1'b0;
            out_raddr        <= '0;
            out_burst_id     <= BID_TLK;
            busy             <= 1'b0;
            done             <= 1'b0;
            hdr_mismatch_cnt <= '0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            cnt_q            <= cnt_d;
            out_rena         <= rena_d;
            out_raddr        <= raddr_d;
            out_burst_id     <= bid_d;
            busy             <= (state_d != IDLE) && (state_d != DONE);
            done             <= (state_d == DONE);
            hdr_mismatch_cnt <= mis_d;
        end
    end

endmodule

// File: tb/tb_et_err_sim_seq.sv
// Scoreboard bench for et_err_sim_seq: expected {burst_id, addr} pairs are
// queued by the stimulus and consumed by a negedge monitor on out_rena.
module tb_et_err_sim_seq;

    localparam int ADDR_W = 12;
    localparam int BLEN   = 2048;
    localparam int DCB    = 2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_live = 1'b0;
    logic              user_ena = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              trig_to_adc = 1'b0;
    logic              out_rena;
    logic [ADDR_W-1:0] out_raddr;
    logic              out_burst_id;
    logic              busy;
    logic              done;
    logic [7:0]        hdr_mismatch_cnt;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W:0] exp_q[$];
    logic [ADDR_W:0] mon_e;

    et_err_sim_seq #(
        .ADDR_W(ADDR_W), .BURST_LEN(BLEN), .DC_BASE(DCB), .HDR_W(3), .HDR_MATCH(3'b010)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_live          (in_live),
        .user_ena         (user_ena),
        .mode             (mode),
        .trig_to_adc      (trig_to_adc),
        .out_rena         (out_rena),
        .out_raddr        (out_raddr),
        .out_burst_id     (out_burst_id),
        .busy             (busy),
        .done             (done),
        .hdr_mismatch_cnt (hdr_mismatch_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every read the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_rena) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rena id=%0d addr=%0d required=no_read", out_burst_id, out_raddr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_burst_id, out_raddr} !== mon_e) begin
                    failures++;
                    $display("FAIL read_seq got id=%0d addr=%0d required id=%0d addr=%0d",
                             out_burst_id, out_raddr, mon_e[ADDR_W], mon_e[ADDR_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int base, input logic bid);
        for (int i = 0; i < BLEN; i++) exp_q.push_back({bid, ADDR_W'(base + i)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d_left required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Start bit, then header bits 0..2.
    task automatic send_hdr(input logic [2:0] h);
        trig_to_adc = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            trig_to_adc = h[i];
            step();
        end
        trig_to_adc = 1'b0;
    endtask

    // E0 edge plus first-read latency checks.
    task automatic start_run(input logic [1:0] m, input string name);
        push_burst(0, 1'b0);
        mode = m;
        in_live = 1'b1;
        user_ena = 1'b1;
        step();
        check({name, "_rena_e0"}, out_rena, 0);
        check({name, "_busy_e0"}, busy, 1);
        step();
        check({name, "_rena_e0p1"}, out_rena, 1);
        check({name, "_addr_e0p1"}, out_raddr, 0);
    endtask

    task automatic end_run();
        in_live = 1'b0;
        step();
        step();
        check("end_idle_done", done, 0);
        check("end_idle_busy", busy, 0);
    endtask

    task automatic dc_once(input string name);
        push_burst(DCB, 1'b1);
        send_hdr(3'b010);
        check({name, "_rena_decision"}, out_rena, 0);
        step();
        check({name, "_rena_dc0"}, out_rena, 1);
        check({name, "_addr_dc0"}, out_raddr, DCB);
        check({name, "_id_dc0"}, out_burst_id, 1);
    endtask

    initial begin
        repeat (3) step();
        check("rst_rena", out_rena, 0);
        check("rst_addr", out_raddr, 0);
        check("rst_id", out_burst_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mis", hdr_mismatch_cnt, 0);
        rst_n = 1'b1;
        step();

        // mode 0 never leaves IDLE
        in_live = 1'b1; user_ena = 1'b1; mode = 2'd0;
        repeat (4) step();
        check("m0_busy", busy, 0);
        in_live = 1'b0; step();

        // mode 1: TLK only, triggers ignored afterwards
        start_run(2'd1, "m1");
        wait_drain("m1_tlk", BLEN + 20);
        step();
        check("m1_done", done, 1);
        check("m1_busy", busy, 0);
        foreach (exp_q[i]) ;
        for (int i = 0; i < 4; i++) begin
            trig_to_adc = (i % 2 == 0);
            step();
        end
        trig_to_adc = 1'b0;
        repeat (6) step();
        check("m1_done_after_trig", done, 1);
        end_run();

        // mode 2: matching header yields one DC burst
        start_run(2'd2, "m2");
        wait_drain("m2_tlk", BLEN + 20);
        repeat (2) step();
        check("m2_wait_busy", busy, 1);
        dc_once("m2");
        wait_drain("m2_dc", BLEN + 20);
        step();
        check("m2_done", done, 1);
        check("m2_mis", hdr_mismatch_cnt, 0);
        end_run();

        // mode 2: 011 rejected, then 010 accepted
        start_run(2'd2, "m2b");
        wait_drain("m2b_tlk", BLEN + 20);
        send_hdr(3'b011);
        repeat (4) step();
        check("m2b_mis", hdr_mismatch_cnt, 1);
        check("m2b_done_early", done, 0);
        dc_once("m2b");
        wait_drain("m2b_dc", BLEN + 20);
        step();
        check("m2b_done", done, 1);
        check("m2b_mis_final", hdr_mismatch_cnt, 1);
        end_run();

        // mode 3: three re-armed bursts, mid-burst trigger ignored
        start_run(2'd3, "m3");
        wait_drain("m3_tlk", BLEN + 20);
        for (int k = 0; k < 3; k++) begin
            dc_once("m3");
            repeat (10) step();
            send_hdr(3'b010);
            wait_drain("m3_dc", BLEN + 20);
            repeat (3) step();
            check("m3_done", done, 0);
            check("m3_busy", busy, 1);
        end
        check("m3_mis", hdr_mismatch_cnt, 0);
        end_run();

        // pause at TLK address 100, then live drop mid-DC
        start_run(2'd2, "pz");
        repeat (100) step();
        check("pz_addr100", out_raddr, 100);
        user_ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("pz_rena_held", out_rena, 0);
            check("pz_addr_held", out_raddr, 100);
        end
        user_ena = 1'b1;
        step();
        check("pz_resume_addr", out_raddr, 101);
        check("pz_resume_rena", out_rena, 1);
        wait_drain("pz_tlk", BLEN + 20);
        send_hdr(3'b110);
        step();
        check("pz_mis", hdr_mismatch_cnt, 1);
        dc_once("pz");
        repeat (50) step();
        in_live = 1'b0;
        @(negedge clk);
        #1;
        exp_q.delete();
        step();
        check("live_drop_rena", out_rena, 0);
        check("live_drop_addr", out_raddr, 0);
        check("live_drop_mis", hdr_mismatch_cnt, 0);
        check("live_drop_busy", busy, 0);

        // restart from address 0, saturate mismatch, async reset mid-header
        start_run(2'd2, "rs");
        wait_drain("rs_tlk", BLEN + 20);
        for (int i = 0; i < 300; i++) send_hdr(3'b111);
        step();
        check("sat_mis", hdr_mismatch_cnt, 255);
        check("sat_no_done", done, 0);
        trig_to_adc = 1'b1;
        step();
        trig_to_adc = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rena", out_rena, 0);
        check("arst_addr", out_raddr, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_mis", hdr_mismatch_cnt, 0);
        in_live = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/et_err_sim_seq.md
# et_err_sim_seq

Parametrised successor to the CDT error-simulation trigger generator. Drives a read-enable/address stream into the ADC-side playback memory so that a link (TLK) error burst and a header-gated data-corruption (DC) burst can be injected into the live data path. Adds the following over the fixed-size generator:
- configurable burst length, address width, header width and match code;
- four run modes, including re-armed repeat injection;
- burst-ID, busy/done and header-mismatch status outputs.

## Interface
- ADDR_W, 12: width of out_raddr.
- BURST_LEN, 2048: addresses issued per burst (TLK and DC), ≥1.
- DC_BASE, 2048: first DC-burst address. Elaboration check: DC_BASE+BURST_LEN ≤ 2**ADDR_W and BURST_LEN ≤ 2**ADDR_W.
- HDR_W, 3: serial header bits following a trigger start bit, 1..8.
- HDR_MATCH, 3'b010: header value that qualifies a trigger (HDR_W bits).

Ports (all synchronous to clk):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_live  in  1  live window; low = synchronous return to IDLE.
- user_ena  in  1  run enable; low while live = pause.
- mode  in  2  0 off, 1 TLK only, 2 TLK+DC once, 3 TLK+DC re-armed; latched on leaving IDLE.
- trig_to_adc  in  1  serial trigger line: start bit then HDR_W header bits, bit 0 first.
- out_rena  out  1  playback read enable.
- out_raddr  out  ADDR_W  playback read address.
- out_burst_id  out  1  0 = TLK burst, 1 = DC burst; valid with out_rena.
- busy  out  1  state not IDLE and not DONE.
- done  out  1  high in DONE.
- hdr_mismatch_cnt  out  8  saturating count of non-matching headers.

## Operation
- States: IDLE, TLK_BURST, WAIT_TRIG, HDR_SHIFT, DC_BURST, DONE.
- IDLE: if in_live & user_ena & mode≠0, latch mode and go to TLK_BURST. mode=0 stays in IDLE.
- TLK_BURST: issue addresses 0..BURST_LEN-1, one per enabled cycle, out_burst_id=0. Afterwards go to DONE if mode=1, else WAIT_TRIG.
- WAIT_TRIG: trig_to_adc=1 is the start bit; go to HDR_SHIFT with bit index 0.
- HDR_SHIFT: shift trig_to_adc into hdr[idx] for HDR_W cycles. On the last bit, compare {bit, earlier bits} against HDR_MATCH.
  - Match: go to DC_BURST.
  - Mismatch: hdr_mismatch_cnt+1 (saturate at 255), go to WAIT_TRIG.
- DC_BURST: issue DC_BASE..DC_BASE+BURST_LEN-1, out_burst_id=1. Afterwards go to DONE if mode=2, else WAIT_TRIG (mode 3; the next DC burst restarts at DC_BASE).
- DONE: outputs idle; held until in_live=0.
- Triggers outside WAIT_TRIG are ignored. Trigger line is treated as header data in HDR_SHIFT.
- user_ena=0 while in_live=1: state, address counter and header index freeze; out_rena=0; out_raddr holds. Resume continues from the next address/bit.
- in_live=0, any state: IDLE next edge; out_rena=0, out_raddr=0, hdr_mismatch_cnt=0. Latched mode is discarded.
- mode changes after leaving IDLE have no effect until the next IDLE.

## Timing
- All outputs are registered. Reset values: out_rena=0, out_raddr=0, out_burst_id=0, busy=0, done=0, hdr_mismatch_cnt=0. State resets to IDLE.
- Edge E0 = first edge with in_live & user_ena & mode≠0 in IDLE. TLK data appears after E0:
  - After E0+1: out_rena=1, out_raddr=0.
  - After E0+BURST_LEN: last address (BURST_LEN-1).
  - After E0+BURST_LEN+1: out_rena=0.
- Edge T = edge sampling the start bit. Header bits are sampled at edges T+1..T+HDR_W. The decision is made at T+HDR_W.
- A match at T+HDR_W gives out_rena=1, out_raddr=DC_BASE after T+HDR_W+1. Gap between DC bursts in mode 3 is ≥ HDR_W+2 cycles.
- out_rena never stays high across a burst boundary: there is at least one low cycle between TLK and DC bursts.
- Address counter is ADDR_W+1 bits internally to detect burst end without wrap.
- An asynchronous rst_n assertion mid-burst zeroes outputs immediately.

## Structure
- Package et_err_sim_pkg: state enum (err_sim_state_t), mode constants (MODE_OFF, MODE_TLK, MODE_ONCE, MODE_REARM), burst-ID constants.
- Sub-module et_err_sim_hdr_deser: serial header capture, bit index, compare against HDR_MATCH. Outputs hdr_done and hdr_match pulses.

## Test plan
- mode=1, BURST_LEN=2048, live+ena held -> 2048 rena cycles with addresses 0..2047 starting one cycle after E0; done=1; no DC burst even with trigger 1,0,1,0 injected.
- mode=2, trigger with header 010 (bits 0,1,0) -> DC rena with DC_BASE=2048 one cycle after the third header bit, 2048 addresses to 4095; done=1; hdr_mismatch_cnt=0.
- mode=2, header 011 then 010 -> hdr_mismatch_cnt=1; only the second trigger yields a DC burst.
- mode=3, three matching triggers -> three DC bursts, each starting at 2048; done stays 0; a trigger sent mid-burst is ignored.
- user_ena low for 5 cycles at TLK address 100 -> rena=0 and address held at 100 for 5 cycles, resuming at 101. in_live low mid-DC-burst -> IDLE; counters cleared; restart begins at address 0.
- rst_n asserted asynchronously mid-HDR_SHIFT -> all outputs 0 before the next edge; 300 mismatching headers -> hdr_mismatch_cnt saturates at 255.
